// File: rtl/store_queue_nway_pkg.sv
// Shared store-queue definitions: entry states, entry payload, index type
// and default sizing. XLEN fixes the width of the entry payload.
package store_queue_nway_pkg;

    localparam int unsigned SQ_SZ_DEF = 8;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned SQ_IDX_W  = $clog2(SQ_SZ_DEF);

    typedef enum logic [1:0] {
        SQ_EMPTY  = 2'd0,
        SQ_ALLOC  = 2'd1,
        SQ_READY  = 2'd2,
        SQ_COMMIT = 2'd3
    } sq_state_e;

    typedef logic [SQ_IDX_W-1:0] sq_idx_t;

    typedef struct packed {
        sq_state_e         state;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   data;
    } sq_entry_t;

    // Address and data are valid once the store has executed.
    function automatic logic is_resolved(input sq_state_e s);
        return (s == SQ_READY) || (s == SQ_COMMIT);
    endfunction

endpackage

// File: rtl/store_queue_nway_age_select.sv
// sq_age_select: scans the older-store window [head, ld_tail) oldest to
// youngest and reports the youngest matching entry (one-hot), whether any
// unresolved entry is younger than it, and whether any unresolved entry
// exists in the window at all.
//   match_vec / unres_vec : per-entry address match / unresolved flags
//   head, ld_tail         : window bounds (ld_tail exclusive)
//   hit_oh_c, hit_c       : youngest match
//   unres_younger_c       : unresolved entry younger than the youngest match
//   unres_any_c           : any unresolved entry in the window
module sq_age_select #(
    parameter  int unsigned SQ_SZ = 8,
    localparam int unsigned IDX_W = $clog2(SQ_SZ)
) (
    input  logic [SQ_SZ-1:0] match_vec,
    input  logic [SQ_SZ-1:0] unres_vec,
    input  logic [IDX_W-1:0] head,
    input  logic [IDX_W-1:0] ld_tail,
    output logic [SQ_SZ-1:0] hit_oh_c,
    output logic             hit_c,
    output logic             unres_younger_c,
    output logic             unres_any_c
);

    logic [IDX_W-1:0] span;
    logic [IDX_W-1:0] idx;

    // Walking by age offset from head keeps the scan wrap-safe.
    always_comb begin
        hit_oh_c        = '0;
        hit_c           = 1'b0;
        unres_younger_c = 1'b0;
        unres_any_c     = 1'b0;
        idx             = '0;
        span            = ld_tail - head;
        for (int k = 0; k < SQ_SZ; k++) begin
            idx = head + IDX_W'(k);
            if (IDX_W'(k) < span) begin
                if (match_vec[idx]) begin
                    hit_oh_c        = '0;
                    hit_oh_c[idx]   = 1'b1;
                    hit_c           = 1'b1;
                    unres_younger_c = 1'b0;
                end else if (unres_vec[idx]) begin
                    unres_any_c     = 1'b1;
                    unres_younger_c = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/store_queue_nway.sv
// store_queue_nway: circular store queue. Allocates at dispatch, captures
// address/data at execute, forwards to younger loads, commits at retire and
// drains committed stores to the D-cache one per cycle. A mispredict restore
// rolls the tail back and squashes uncommitted entries.
// Ports: dispatch (disp_count, sq_spots, sq_tail), execute (ex_*), load
// lookup (ld_*), retire (ret_count), drain (mem_req_*), restore (restore_*).
// Optional build macro SQ_LD_SPEC_EN: loads ignore unresolved older stores,
// ld_stall is held 0 and an extra ld_spec output flags that an unresolved
// older store existed.
module store_queue_nway
    import store_queue_nway_pkg::*;
#(
    parameter  int unsigned SQ_SZ   = SQ_SZ_DEF,
    parameter  int unsigned DISP_W  = 2,
    parameter  int unsigned RET_W   = 2,
    localparam int unsigned IDX_W   = $clog2(SQ_SZ),
    localparam int unsigned CNT_W   = $clog2(SQ_SZ + 1),
    localparam int unsigned DISP_CW = $clog2(DISP_W + 1),
    localparam int unsigned RET_CW  = $clog2(RET_W + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [DISP_CW-1:0] disp_count,
    output logic [DISP_CW-1:0] sq_spots,
    output logic [IDX_W-1:0]   sq_tail,
    input  logic               ex_valid,
    input  logic [IDX_W-1:0]   ex_idx,
    input  logic [XLEN-1:0]    ex_addr,
    input  logic [XLEN-1:0]    ex_data,
    input  logic               ld_valid,
    input  logic [XLEN-1:0]    ld_addr,
    input  logic [IDX_W-1:0]   ld_tail,
    output logic               ld_hit,
    output logic [XLEN-1:0]    ld_data,
    output logic               ld_stall,
    input  logic [RET_CW-1:0]  ret_count,
    output logic               mem_req_valid,
    output logic [XLEN-1:0]    mem_req_addr,
    output logic [XLEN-1:0]    mem_req_data,
    input  logic               mem_req_ack,
    input  logic               restore_valid,
    input  logic [IDX_W-1:0]   restore_tail
`ifdef SQ_LD_SPEC_EN
    ,
    output logic               ld_spec
`endif
);

    localparam logic [CNT_W-1:0] SQ_SZ_C  = CNT_W'(SQ_SZ);
    localparam logic [CNT_W-1:0] DISP_W_C = CNT_W'(DISP_W);

    sq_entry_t        q   [SQ_SZ];
    sq_entry_t        q_n [SQ_SZ];
    logic [IDX_W-1:0] head, head_n, tail, tail_n, commit_ptr, commit_n;
    logic [CNT_W-1:0] count, count_n, free_cnt;
    logic [IDX_W-1:0] slot, squash_len, squash_off, restore_span;
    logic             drain;

    // Next-state for entries and pointers.
    always_comb begin
        q_n          = q;
        head_n       = head;
        tail_n       = tail;
        commit_n     = commit_ptr;
        count_n      = count;
        slot         = '0;
        squash_len   = '0;
        squash_off   = '0;
        restore_span = '0;
        drain        = mem_req_valid && mem_req_ack;

        if (ex_valid && (q[ex_idx].state == SQ_ALLOC)) begin
            q_n[ex_idx].state = SQ_READY;
            q_n[ex_idx].addr  = ex_addr;
            q_n[ex_idx].data  = ex_data;
        end

        for (int i = 0; i < RET_W; i++) begin
            if (RET_CW'(i) < ret_count) begin
                slot = commit_ptr + IDX_W'(i);
                q_n[slot].state = SQ_COMMIT;
            end
        end
        commit_n = commit_ptr + IDX_W'(ret_count);

        if (drain) begin
            q_n[head].state = SQ_EMPTY;
            head_n = head + IDX_W'(1);
        end

        if (restore_valid) begin
            // Restore wins over dispatch; squash [restore_tail, old tail).
            tail_n     = restore_tail;
            squash_len = tail - restore_tail;
            for (int i = 0; i < SQ_SZ; i++) begin
                squash_off = IDX_W'(i) - restore_tail;
                if (squash_off < squash_len) begin
                    q_n[i].state = SQ_EMPTY;
                end
            end
            restore_span = restore_tail - head_n;
            if (restore_tail == head_n) begin
                // Equal pointers are ambiguous: full only if nothing left.
                count_n = ((count == SQ_SZ_C) && !drain) ? SQ_SZ_C : '0;
            end else begin
                count_n = CNT_W'(restore_span);
            end
        end else begin
            for (int i = 0; i < DISP_W; i++) begin
                if (DISP_CW'(i) < disp_count) begin
                    slot = tail + IDX_W'(i);
                    q_n[slot].state = SQ_ALLOC;
                end
            end
            tail_n  = tail + IDX_W'(disp_count);
            count_n = count + CNT_W'(disp_count) - CNT_W'(drain);
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SQ_SZ; i++) begin
                q[i].state <= SQ_EMPTY;
                q[i].addr  <= '0;
                q[i].data  <= '0;
            end
            head       <= '0;
            tail       <= '0;
            commit_ptr <= '0;
            count      <= '0;
        end else begin
            q          <= q_n;
            head       <= head_n;
            tail       <= tail_n;
            commit_ptr <= commit_n;
            count      <= count_n;
        end
    end

    // Retiring a store that has not executed is a protocol error.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < RET_W; i++) begin
                if (RET_CW'(i) < ret_count) begin
                    assert (q[commit_ptr + IDX_W'(i)].state == SQ_READY)
                    else $error("store_queue_nway: retire of entry %0d which is not READY",
                                commit_ptr + IDX_W'(i));
                end
            end
        end
    end

    // Dispatch credit from the registered count only.
    assign free_cnt = SQ_SZ_C - count;
    assign sq_spots = (free_cnt > DISP_W_C) ? DISP_CW'(DISP_W) : DISP_CW'(free_cnt);
    assign sq_tail  = tail;

    assign mem_req_valid = (q[head].state == SQ_COMMIT);
    assign mem_req_addr  = q[head].addr;
    assign mem_req_data  = q[head].data;

    // Load forwarding.
    logic [SQ_SZ-1:0] match_vec, unres_vec, hit_oh;
    logic             hit_any, unres_younger, unres_any;
    logic [XLEN-1:0]  fwd_data;

    always_comb begin
        match_vec = '0;
        unres_vec = '0;
        fwd_data  = '0;
        for (int i = 0; i < SQ_SZ; i++) begin
            match_vec[i] = is_resolved(q[i].state) && (q[i].addr == ld_addr);
            unres_vec[i] = (q[i].state == SQ_ALLOC);
            if (hit_oh[i]) begin
                fwd_data = fwd_data | q[i].data;
            end
        end
    end

    sq_age_select #(.SQ_SZ(SQ_SZ)) u_age_select (
        .match_vec       (match_vec),
        .unres_vec       (unres_vec),
        .head            (head),
        .ld_tail         (ld_tail),
        .hit_oh_c        (hit_oh),
        .hit_c           (hit_any),
        .unres_younger_c (unres_younger),
        .unres_any_c     (unres_any)
    );

`ifdef SQ_LD_SPEC_EN
    assign ld_stall = 1'b0;
    assign ld_hit   = ld_valid && hit_any;
    assign ld_spec  = ld_valid && unres_any;
`else
    assign ld_stall = ld_valid && (hit_any ? unres_younger : unres_any);
    assign ld_hit   = ld_valid && hit_any && !ld_stall;
`endif
    assign ld_data  = ld_hit ? fwd_data : '0;

endmodule

// File: tb/tb_store_queue_nway.sv
// Directed bench for store_queue_nway (SQ_SZ=8, DISP_W=2, RET_W=2).
// Drained stores are checked against a scoreboard filled at retire time.
// Honors SQ_LD_SPEC_EN for the speculative-load build.
module tb_store_queue_nway;
    import store_queue_nway_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

    logic        clock;
    logic        reset;
    logic [1:0]  disp_count;
    logic [1:0]  sq_spots;
    logic [2:0]  sq_tail;
    logic        ex_valid;
    logic [2:0]  ex_idx;
    logic [31:0] ex_addr, ex_data;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  ld_tail;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic [1:0]  ret_count;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr, mem_req_data;
    logic        mem_req_ack;
    logic        restore_valid;
    logic [2:0]  restore_tail;
`ifdef SQ_LD_SPEC_EN
    logic        ld_spec;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_addr [8];
    logic [31:0] m_data [8];
    int          m_commit = 0;
    sb_t         sb [$];

    store_queue_nway dut (
        .clock         (clock),
        .reset         (reset),
        .disp_count    (disp_count),
        .sq_spots      (sq_spots),
        .sq_tail       (sq_tail),
        .ex_valid      (ex_valid),
        .ex_idx        (ex_idx),
        .ex_addr       (ex_addr),
        .ex_data       (ex_data),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_tail       (ld_tail),
        .ld_hit        (ld_hit),
        .ld_data       (ld_data),
        .ld_stall      (ld_stall),
        .ret_count     (ret_count),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_ack   (mem_req_ack),
        .restore_valid (restore_valid),
        .restore_tail  (restore_tail)
`ifdef SQ_LD_SPEC_EN
        ,
        .ld_spec       (ld_spec)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        disp_count = '0; ex_valid = 1'b0; ex_idx = '0; ex_addr = '0; ex_data = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_tail = '0; ret_count = '0;
        mem_req_ack = 1'b0; restore_valid = 1'b0; restore_tail = '0;
        tick();
        tick();
        reset = 1'b0;
        m_commit = 0;
        sb.delete();
    endtask

    task automatic dispatch(input logic [1:0] n);
        disp_count = n;
        tick();
        disp_count = '0;
    endtask

    task automatic execute(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
        ex_valid = 1'b1; ex_idx = idx; ex_addr = a; ex_data = d;
        m_addr[idx] = a;
        m_data[idx] = d;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic retire(input logic [1:0] n);
        for (int i = 0; i < int'(n); i++) begin
            sb.push_back('{addr: m_addr[(m_commit + i) % 8], data: m_data[(m_commit + i) % 8]});
        end
        m_commit = (m_commit + int'(n)) % 8;
        ret_count = n;
        tick();
        ret_count = '0;
    endtask

    task automatic drain_one(input string tag);
        sb_t e;
        e = '0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed valid=%0b", tag, mem_req_valid);
        end else begin
            e = sb.pop_front();
            check({tag, ".valid"}, 32'(mem_req_valid), 32'd1);
            check({tag, ".addr"}, mem_req_addr, e.addr);
            check({tag, ".data"}, mem_req_data, e.data);
        end
        mem_req_ack = 1'b1;
        tick();
        mem_req_ack = 1'b0;
    endtask

    task automatic load(input logic [2:0] t, input logic [31:0] a, input logic eh,
                        input logic [31:0] ed, input logic es, input logic esp, input string tag);
        ld_valid = 1'b1; ld_tail = t; ld_addr = a;
        #1;
        check({tag, ".hit"}, 32'(ld_hit), 32'(eh));
        check({tag, ".data"}, ld_data, ed);
`ifdef SQ_LD_SPEC_EN
        check({tag, ".stall"}, 32'(ld_stall), 32'd0);
        check({tag, ".spec"}, 32'(ld_spec), 32'(esp));
`else
        check({tag, ".stall"}, 32'(ld_stall), 32'(es && !esp ? 1'b1 : es));
`endif
        ld_valid = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset state.
        check("rst.spots", 32'(sq_spots), 32'd2);
        check("rst.tail", 32'(sq_tail), 32'd0);
        check("rst.memv", 32'(mem_req_valid), 32'd0);
        check("rst.hit", 32'(ld_hit), 32'd0);
        check("rst.stall", 32'(ld_stall), 32'd0);
        check("rst.data", ld_data, 32'd0);
        load(3'd0, 32'h100, 1'b0, 32'd0, 1'b0, 1'b0, "rst.load");

        // Fill at 2 per cycle.
        for (int c = 0; c < 4; c++) begin
            check($sformatf("fill%0d.tail", c), 32'(sq_tail), 32'((2 * c) % 8));
            check($sformatf("fill%0d.spots", c), 32'(sq_spots), 32'd2);
            dispatch(2'd2);
        end
        check("full.tail", 32'(sq_tail), 32'd0);
        check("full.spots", 32'(sq_spots), 32'd0);
        check("full.memv", 32'(mem_req_valid), 32'd0);

        // Older unresolved store behind a matching one.
        execute(3'd0, 32'h100, 32'hA);
`ifdef SQ_LD_SPEC_EN
        load(3'd2, 32'h100, 1'b1, 32'hA, 1'b0, 1'b1, "alias.stall");
        load(3'd3, 32'h104, 1'b0, 32'h0, 1'b0, 1'b1, "nocand.stall");
`else
        load(3'd2, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0, "alias.stall");
        load(3'd3, 32'h104, 1'b0, 32'h0, 1'b1, 1'b0, "nocand.stall");
`endif

        // Both older stores resolved.
        execute(3'd1, 32'h100, 32'hB);
        load(3'd2, 32'h100, 1'b1, 32'hB, 1'b0, 1'b0, "fwd.young");
        load(3'd2, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, "fwd.miss");
        load(3'd1, 32'h100, 1'b1, 32'hA, 1'b0, 1'b0, "fwd.old");
        load(3'd0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, "fwd.none");
        ld_valid = 1'b0; ld_tail = 3'd2; ld_addr = 32'h100;
        #1;
        check("novalid.hit", 32'(ld_hit), 32'd0);
        check("novalid.data", ld_data, 32'd0);

        // Commit and hold the drain request until acked.
        retire(2'd2);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("hold%0d.valid", c), 32'(mem_req_valid), 32'd1);
            check($sformatf("hold%0d.addr", c), mem_req_addr, 32'h100);
            tick();
        end
        drain_one("drain0");
        check("drain0.spots", 32'(sq_spots), 32'd1);
        drain_one("drain1");
        check("drain1.spots", 32'(sq_spots), 32'd2);
        check("drain1.memv", 32'(mem_req_valid), 32'd0);

        // Restore with a same-cycle dispatch.
        do_reset();
        dispatch(2'd2); dispatch(2'd2); dispatch(2'd2);
        execute(3'd0, 32'h300, 32'h1);
        execute(3'd1, 32'h304, 32'h2);
        execute(3'd2, 32'h308, 32'h3);
        retire(2'd2);
        restore_valid = 1'b1; restore_tail = 3'd3; disp_count = 2'd2;
        tick();
        restore_valid = 1'b0; disp_count = '0;
        check("rest.tail", 32'(sq_tail), 32'd3);
        check("rest.spots", 32'(sq_spots), 32'd2);
        check("rest.memv", 32'(mem_req_valid), 32'd1);
        load(3'd6, 32'h308, 1'b1, 32'h3, 1'b0, 1'b0, "rest.fwd");
        load(3'd6, 32'h30C, 1'b0, 32'h0, 1'b0, 1'b0, "rest.miss");
        load(3'd6, 32'h300, 1'b1, 32'h1, 1'b0, 1'b0, "rest.commit");
        drain_one("rest.d0");
        drain_one("rest.d1");
        dispatch(2'd2); dispatch(2'd2);
        check("rest.spots5", 32'(sq_spots), 32'd2);
        dispatch(2'd2);
        check("rest.spots7", 32'(sq_spots), 32'd1);
        check("rest.tail7", 32'(sq_tail), 32'd1);

        // Move head to 6, then forward across the wrap.
        do_reset();
        dispatch(2'd2); dispatch(2'd2); dispatch(2'd2);
        for (int i = 0; i < 6; i++) begin
            execute(3'(i), 32'h400 + 32'(4 * i), 32'h50 + 32'(i));
        end
        retire(2'd2); retire(2'd2); retire(2'd2);
        for (int i = 0; i < 6; i++) begin
            drain_one($sformatf("wrap.d%0d", i));
        end
        check("empty.memv", 32'(mem_req_valid), 32'd0);
        check("empty.spots", 32'(sq_spots), 32'd2);
        load(3'd6, 32'h400, 1'b0, 32'h0, 1'b0, 1'b0, "empty.load");
        dispatch(2'd2); dispatch(2'd2);
        check("wrap.tail", 32'(sq_tail), 32'd2);
        execute(3'd7, 32'h200, 32'h77);
`ifdef SQ_LD_SPEC_EN
        load(3'd2, 32'h200, 1'b1, 32'h77, 1'b0, 1'b1, "wrap.stall");
`else
        load(3'd2, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0, "wrap.stall");
`endif
        execute(3'd1, 32'h200, 32'h11);
        execute(3'd6, 32'h208, 32'h66);
        execute(3'd0, 32'h20C, 32'h0C);
        load(3'd2, 32'h200, 1'b1, 32'h11, 1'b0, 1'b0, "wrap.young");
        load(3'd0, 32'h200, 1'b1, 32'h77, 1'b0, 1'b0, "wrap.old");
        load(3'd2, 32'h208, 1'b1, 32'h66, 1'b0, 1'b0, "wrap.head");
        load(3'd7, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, "wrap.narrow");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
